// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the 32-bit MIPS pipeline.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_ENC = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_FILL = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Widened so a word near the top of the address space cannot wrap into range.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned bytes);
    logic [32:0] last;
    last = {1'b0, addr} + 33'd3;
    return last >= 33'(bytes);
  endfunction
endpackage

// File: rtl/if_skid_reg.sv
// One-entry pc+instruction holding register; keeps the in-flight fetch while ID stalls.
module if_skid_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [31:0]        pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [31:0]        pc_o,
  output logic [INSTR_W-1:0] instr_o
);
  logic [31:0]        pc_q;
  logic [INSTR_W-1:0] instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC and the IF/ID register over a 1-cycle synchronous instruction memory.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0]        RESET_PC   = RESET_PC_DEF,
  parameter int unsigned        IMEM_BYTES = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [31:0]        pc_out,
  output logic [31:0]        ifid_pc_o,
  output logic [31:0]        ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic               fetch_err_o
);
  fetch_state_e       state_q;
  logic [31:0]        pc_q, pc_d1_q, ifid_pc_q, ifid_pc4_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic               ifid_valid_q, fetch_err_q;

  logic               skid_load, skid_clear;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        ld_pc;
  logic [INSTR_W-1:0] ld_instr;
  logic               ld_oob;

  // Memory output is overwritten on the stall edge, so the live word goes to the skid.
  assign skid_load  = !redirect_i && stall_i && (state_q == FETCH_RUN);
  assign skid_clear = redirect_i;

  if_skid_reg u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .pc_i   (pc_d1_q),
    .instr_i(imem_instr_i),
    .pc_o   (skid_pc),
    .instr_o(skid_instr)
  );

  assign ld_pc    = (state_q == FETCH_HOLD) ? skid_pc    : pc_d1_q;
  assign ld_instr = (state_q == FETCH_HOLD) ? skid_instr : imem_instr_i;
  assign ld_oob   = addr_oob(ld_pc, IMEM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_FILL;
      pc_q         <= RESET_PC;
      pc_d1_q      <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_i & ~32'd3;
      ifid_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      state_q      <= FETCH_FILL;
    end else if (!stall_i) begin
      pc_d1_q <= pc_q;
      pc_q    <= pc_q + 32'd4;
      state_q <= FETCH_RUN;
      if (state_q == FETCH_FILL) begin
        ifid_valid_q <= 1'b0;
      end else begin
        ifid_pc_q    <= ld_pc;
        ifid_pc4_q   <= ld_pc + 32'd4;
        ifid_valid_q <= 1'b1;
        ifid_instr_q <= ld_oob ? NOP_INSTR : ld_instr;
        fetch_err_q  <= ld_oob;
      end
    end else if (state_q == FETCH_RUN) begin
      state_q <= FETCH_HOLD;
    end
  end

  assign pc_out       = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign fetch_err_o  = fetch_err_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized stall/redirect against a stream model.
module tb_if_fetch_unit;
  localparam int unsigned IMEM = 64;
  localparam logic [31:0] NOP  = 32'h0BAD_F00D;

  logic        clk = 1'b0, rst = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_instr_i = '0;
  logic [31:0] pc_out, ifid_pc_o, ifid_pc4_o, ifid_instr_o;
  logic        ifid_valid_o, fetch_err_o;
  int          errs = 0, checks = 0;

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_instr_i(imem_instr_i), .pc_out(pc_out),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address, defined everywhere.
  function automatic logic [31:0] im(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1111};
  endfunction

  always @(posedge clk) imem_instr_i <= im(pc_out);

  // Stream model: after a restart the unit needs one priming edge, then delivers
  // consecutive words on each unstalled edge.
  logic [31:0] m_next, m_pc, m_pc4, m_instr;
  logic        m_primed, m_valid, m_err;

  function automatic logic oob(input logic [31:0] a);
    return (64'(a) + 64'd3) >= 64'(IMEM);
  endfunction

  task automatic model_reset();
    m_next = 32'h0; m_primed = 1'b0; m_pc = '0; m_pc4 = '0;
    m_instr = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
    if (r) begin
      m_next = t & 32'hFFFF_FFFC; m_primed = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    end else if (!s) begin
      if (!m_primed) begin
        m_primed = 1'b1; m_valid = 1'b0;
      end else begin
        m_pc = m_next; m_pc4 = m_next + 32'd4; m_valid = 1'b1;
        m_err = oob(m_next); m_instr = m_err ? NOP : im(m_next);
        m_next = m_next + 32'd4;
      end
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall_i = s; redirect_i = r; redirect_pc_i = t;
    @(posedge clk);
    model_edge(s, r, t);
    #1;
    stall_i = 1'b0; redirect_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== 32'h0) begin errs++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    checks++; if (ifid_valid_o !== 1'b0 || fetch_err_o !== 1'b0) begin errs++;
      $display("FAIL rst_flags: valid=%b err=%b want 0 0", ifid_valid_o, fetch_err_o); end
    checks++; if (ifid_pc_o !== 0 || ifid_pc4_o !== 0 || ifid_instr_o !== 0) begin errs++;
      $display("FAIL rst_ifid: pc=%h pc4=%h instr=%h want 0", ifid_pc_o, ifid_pc4_o, ifid_instr_o); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (k == 1) begin
        if (ifid_valid_o !== 1'b0) begin errs++; $display("FAIL stream_first_edge: valid=%b want 0", ifid_valid_o); end
      end else if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'(4*(k-2)) || ifid_instr_o !== im(32'(4*(k-2)))
                   || ifid_pc4_o !== 32'(4*(k-1))) begin
        errs++;
        $display("FAIL stream_k%0d: valid=%b pc=%h pc4=%h instr=%h want 1 %h %h %h", k, ifid_valid_o,
                 ifid_pc_o, ifid_pc4_o, ifid_instr_o, 32'(4*(k-2)), 32'(4*(k-1)), im(32'(4*(k-2))));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, '0);
      checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h4 || ifid_instr_o !== im(32'h4)) begin errs++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h want 1 00000004", k, ifid_valid_o, ifid_pc_o); end
    end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_pc_o !== 32'h8 || ifid_instr_o !== im(32'h8) || ifid_valid_o !== 1'b1) begin errs++;
      $display("FAIL stall_release_pc8: pc=%h instr=%h want 00000008 %h", ifid_pc_o, ifid_instr_o, im(32'h8)); end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_pc_o !== 32'hC || ifid_instr_o !== im(32'hC) || ifid_valid_o !== 1'b1) begin errs++;
      $display("FAIL stall_release_pc12: pc=%h instr=%h want 0000000c %h", ifid_pc_o, ifid_instr_o, im(32'hC)); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h22);
    checks++; if (ifid_valid_o !== 1'b0 || pc_out !== 32'h20) begin errs++;
      $display("FAIL redir_flush: valid=%b pc_out=%h want 0 00000020", ifid_valid_o, pc_out); end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b0) begin errs++; $display("FAIL redir_bubble: valid=%b want 0", ifid_valid_o); end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h20 || ifid_instr_o !== im(32'h20)) begin errs++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h want 1 00000020 %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, im(32'h20)); end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_pc_o !== 32'h24 || ifid_instr_o !== im(32'h24)) begin errs++;
      $display("FAIL redir_next: pc=%h want 00000024", ifid_pc_o); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h30);
    checks++; if (ifid_valid_o !== 1'b0 || pc_out !== 32'h30) begin errs++;
      $display("FAIL rs_flush: valid=%b pc_out=%h want 0 00000030", ifid_valid_o, pc_out); end
    step(1'b1, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b0 || pc_out !== 32'h30) begin errs++;
      $display("FAIL rs_fill_hold: valid=%b pc_out=%h want 0 00000030", ifid_valid_o, pc_out); end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h30 || ifid_instr_o !== im(32'h30)) begin errs++;
      $display("FAIL rs_first: valid=%b pc=%h instr=%h want 1 00000030 %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, im(32'h30)); end
  endtask

  task automatic test_range();
    logic [31:0] want_pc [4] = '{32'h38, 32'h3C, 32'h40, 32'h44};
    logic        want_err[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    step(1'b0, 1'b1, 32'h38);
    step(1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (ifid_valid_o !== 1'b1 || ifid_pc_o !== want_pc[k] || fetch_err_o !== want_err[k] ||
          ifid_instr_o !== (want_err[k] ? NOP : im(want_pc[k]))) begin
        errs++;
        $display("FAIL range_%h: valid=%b pc=%h err=%b instr=%h want 1 %h %b %h", want_pc[k], ifid_valid_o,
                 ifid_pc_o, fetch_err_o, ifid_instr_o, want_pc[k], want_err[k], want_err[k] ? NOP : im(want_pc[k]));
      end
    end
    step(1'b0, 1'b1, 32'h0);
    repeat (2) step(1'b0, 1'b0, '0);
    checks++; if (fetch_err_o !== 1'b0 || ifid_pc_o !== 32'h0 || ifid_instr_o !== im(32'h0)) begin errs++;
      $display("FAIL range_recover: err=%b pc=%h want 0 00000000", fetch_err_o, ifid_pc_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, '0);
    stall_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (pc_out !== 0 || ifid_valid_o !== 0 || fetch_err_o !== 0 || ifid_pc_o !== 0 ||
                  ifid_pc4_o !== 0 || ifid_instr_o !== 0) begin errs++;
      $display("FAIL async_rst: pc_out=%h valid=%b err=%b pc=%h pc4=%h instr=%h want all 0", pc_out,
               ifid_valid_o, fetch_err_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o); end
    @(posedge clk);
    #1 rst = 1'b0; stall_i = 1'b0;
    model_reset();
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b0) begin errs++; $display("FAIL async_refill: valid=%b want 0", ifid_valid_o); end
    step(1'b0, 1'b0, '0);
    checks++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h0 || ifid_instr_o !== im(32'h0)) begin errs++;
      $display("FAIL async_refetch: valid=%b pc=%h instr=%h want 1 00000000 %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, im(32'h0)); end
  endtask

  task automatic test_random();
    logic        s, r;
    logic [31:0] t, exp_pcout;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       t = 32'($urandom_range(0, 20) * 4);
        1:       t = 32'($urandom_range(0, 80));
        2:       t = 32'hFFFF_FFF4;
        default: t = 32'h34;
      endcase
      step(s, r, t);
      exp_pcout = m_primed ? m_next + 32'd4 : m_next;
      checks++;
      if (pc_out !== exp_pcout || ifid_valid_o !== m_valid || fetch_err_o !== m_err ||
          ifid_pc_o !== m_pc || ifid_pc4_o !== m_pc4 || ifid_instr_o !== m_instr) begin
        errs++;
        $display("FAIL rand_cyc%0d: pc_out=%h v=%b e=%b pc=%h pc4=%h i=%h want %h %b %b %h %h %h", n, pc_out,
                 ifid_valid_o, fetch_err_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, exp_pcout, m_valid, m_err,
                 m_pc, m_pc4, m_instr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_range();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
